event_encoder: RTL

Parametrised event encoder for the TD board I/O path. It captures rising edges on `WIDTH` independent request lines into a pending register and arbitrates among them, fixed-priority or round-robin. It presents one binary index at a time to a downstream consumer over a valid/ready handshake. It replaces the combinational one-hot encoder wherever inputs can assert concurrently or faster than the consumer reads, so that no event is silently dropped or merged.

---
 rtl/event_encoder.sv | 92 +++++++++
 1 files changed

// File: rtl/event_encoder.sv
// Edge-capturing event encoder: pending register, fixed/round-robin
// arbiter and a valid/ready code output.
module event_encoder #(
  parameter int  WIDTH  = 16,
  parameter int  MODE   = 0,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WIDTH-1:0]  signal,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [WIDTH-1:0]  pending,
  output logic              lost
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sig_d;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  clr;
  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] win;
  logic [CODE_W-1:0] ptr_nxt;

  assign rise = signal & ~sig_d;

  always_comb begin
    clr = '0;
    if (valid && ready) clr[code] = 1'b1;
  end

  // Search wraps modulo WIDTH so a non-power-of-two width never
  // yields an out-of-range code.
  always_comb begin
    int   idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = k + ((MODE == 1) ? int'(ptr) : 0);
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!found && pending[CODE_W'(idx)]) begin
        win   = CODE_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign ptr_nxt = (code == CODE_W'(WIDTH - 1)) ?
                   '0 : code + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_d   <= '1;
      pending <= '0;
      lost    <= 1'b0;
      state   <= IDLE;
      code    <= '0;
      valid   <= 1'b0;
      ptr     <= '0;
    end else begin
      sig_d   <= signal;
      pending <= rise | (pending & ~clr);
      lost    <= |(rise & pending & ~clr);
      unique case (state)
        IDLE: begin
          if (|pending) begin
            code  <= win;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            ptr   <= ptr_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
